// File: rtl/cdb_arbiter.sv
// cdb_arbiter: grants one functional-unit completion per cycle onto the registered common data bus
module cdb_arbiter #(
   parameter int NUM_FU  = 8,
   parameter int ORDER_W = 64,
   parameter int POLICY  = 0,
   parameter int STALL_W = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      flush,
   input  logic [NUM_FU-1:0]         req,
   input  logic [NUM_FU*5-1:0]       req_rd,
   input  logic [NUM_FU*32-1:0]      req_data,
   input  logic [NUM_FU*ORDER_W-1:0] req_order,
   output logic [NUM_FU-1:0]         grant,
   output logic                      cdb_valid,
   output logic [$clog2(NUM_FU)-1:0] cdb_fu_id,
   output logic [4:0]                cdb_rd,
   output logic [31:0]               cdb_data,
   output logic [ORDER_W-1:0]        cdb_order,
   output logic [STALL_W-1:0]        stall_cnt
);
   localparam int IDX_W = $clog2(NUM_FU);

   logic               cand_vld;
   logic [IDX_W-1:0]   cand_idx;
   logic [ORDER_W-1:0] best_ord;
   logic               take;
   logic               multi;
   logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [STALL_W-1:0] stall_q, stall_d;
   logic               cdb_valid_q, cdb_valid_d;
   logic [IDX_W-1:0]   cdb_fu_id_q, cdb_fu_id_d;
   logic [4:0]         cdb_rd_q, cdb_rd_d;
   logic [31:0]        cdb_data_q, cdb_data_d;
   logic [ORDER_W-1:0] cdb_order_q, cdb_order_d;

   // pick a candidate: first requester from rr_ptr upward, or smallest order tag (lowest index on ties)
   always_comb begin
      cand_vld = 1'b0;
      cand_idx = '0;
      best_ord = '0;
      if (POLICY == 0) begin
         for (int k = NUM_FU - 1; k >= 0; k--) begin
            if (req[(int'(rr_ptr_q) + k) % NUM_FU]) begin
               cand_vld = 1'b1;
               cand_idx = IDX_W'((int'(rr_ptr_q) + k) % NUM_FU);
            end
         end
      end else begin
         for (int i = 0; i < NUM_FU; i++) begin
            if (req[i] && (!cand_vld || req_order[i*ORDER_W +: ORDER_W] < best_ord)) begin
               cand_vld = 1'b1;
               cand_idx = IDX_W'(i);
               best_ord = req_order[i*ORDER_W +: ORDER_W];
            end
         end
      end
   end

   assign take  = cand_vld & ~rst & ~flush;
   assign grant = take ? ({{(NUM_FU-1){1'b0}}, 1'b1} << cand_idx) : '0;
   assign multi = |(req & (req - NUM_FU'(1)));

   // next state: latch the winner onto the bus, advance the pointer past it, count contended cycles
   always_comb begin
      cdb_valid_d = take;
      cdb_fu_id_d = take ? cand_idx : cdb_fu_id_q;
      cdb_rd_d    = take ? req_rd[int'(cand_idx)*5 +: 5] : cdb_rd_q;
      cdb_data_d  = take ? req_data[int'(cand_idx)*32 +: 32] : cdb_data_q;
      cdb_order_d = take ? req_order[int'(cand_idx)*ORDER_W +: ORDER_W] : cdb_order_q;
      rr_ptr_d    = !take ? rr_ptr_q : (cand_idx == IDX_W'(NUM_FU - 1)) ? '0 : cand_idx + IDX_W'(1);
      stall_d     = (!flush && multi && stall_q != '1) ? stall_q + STALL_W'(1) : stall_q;
   end

   // state registers; reset clears the bus and discards any pending broadcast
   always_ff @(posedge clk) begin
      if (rst) begin
         cdb_valid_q <= 1'b0;
         cdb_fu_id_q <= '0;
         cdb_rd_q    <= '0;
         cdb_data_q  <= '0;
         cdb_order_q <= '0;
         rr_ptr_q    <= '0;
         stall_q     <= '0;
      end else begin
         cdb_valid_q <= cdb_valid_d;
         cdb_fu_id_q <= cdb_fu_id_d;
         cdb_rd_q    <= cdb_rd_d;
         cdb_data_q  <= cdb_data_d;
         cdb_order_q <= cdb_order_d;
         rr_ptr_q    <= rr_ptr_d;
         stall_q     <= stall_d;
      end
   end

   assign cdb_valid = cdb_valid_q;
   assign cdb_fu_id = cdb_fu_id_q;
   assign cdb_rd    = cdb_rd_q;
   assign cdb_data  = cdb_data_q;
   assign cdb_order = cdb_order_q;
   assign stall_cnt = stall_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed checks of round-robin, oldest-first, flush, saturation and reset
module tb_cdb_arbiter;
   logic        clk = 1'b0;
   logic        rst, flush;
   logic [7:0]  req;
   logic [39:0] req_rd;
   logic [255:0] req_data;
   logic [511:0] req_order;

   logic [7:0] g_rr, g_of, g_sat;
   logic v_rr, v_of, v_sat;
   logic [2:0] id_rr, id_of, id_sat;
   logic [4:0] rd_rr, rd_of, rd_sat;
   logic [31:0] d_rr, d_of, d_sat;
   logic [63:0] o_rr, o_of, o_sat;
   logic [31:0] s_rr, s_of;
   logic [3:0] s_sat;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   cdb_arbiter #(.NUM_FU(8), .ORDER_W(64), .POLICY(0), .STALL_W(32)) u_rr (
      .clk(clk), .rst(rst), .flush(flush), .req(req), .req_rd(req_rd), .req_data(req_data),
      .req_order(req_order), .grant(g_rr), .cdb_valid(v_rr), .cdb_fu_id(id_rr), .cdb_rd(rd_rr),
      .cdb_data(d_rr), .cdb_order(o_rr), .stall_cnt(s_rr));

   cdb_arbiter #(.NUM_FU(8), .ORDER_W(64), .POLICY(1), .STALL_W(32)) u_of (
      .clk(clk), .rst(rst), .flush(flush), .req(req), .req_rd(req_rd), .req_data(req_data),
      .req_order(req_order), .grant(g_of), .cdb_valid(v_of), .cdb_fu_id(id_of), .cdb_rd(rd_of),
      .cdb_data(d_of), .cdb_order(o_of), .stall_cnt(s_of));

   cdb_arbiter #(.NUM_FU(8), .ORDER_W(64), .POLICY(0), .STALL_W(4)) u_sat (
      .clk(clk), .rst(rst), .flush(flush), .req(req), .req_rd(req_rd), .req_data(req_data),
      .req_order(req_order), .grant(g_sat), .cdb_valid(v_sat), .cdb_fu_id(id_sat), .cdb_rd(rd_sat),
      .cdb_data(d_sat), .cdb_order(o_sat), .stall_cnt(s_sat));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_fu(input int i, input logic [4:0] rd, input logic [31:0] d, input logic [63:0] o);
      req_rd[5*i +: 5]     = rd;
      req_data[32*i +: 32] = d;
      req_order[64*i +: 64] = o;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; req = 8'hFF; req_rd = '0; req_data = '0; req_order = '0;
      #1;
      chk("grant_in_rst", {48'd0, g_rr, g_of}, 64'd0);
      cyc();
      cyc();
      chk("rst_valid", {61'd0, v_rr, v_of, v_sat}, 64'd0);
      chk("rst_stall", s_rr, 64'd0);
      chk("rst_payload", {o_rr[7:0], d_rr[7:0], 3'd0, rd_rr, 5'd0, id_rr}, 64'd0);
      req = 8'h00;
      rst = 1'b0;
      cyc();

      // single requester
      set_fu(2, 5'd5, 32'hDEADBEEF, 64'd0);
      req = 8'b0000_0100;
      #1;
      chk("single_grant", g_rr, 64'h04);
      cyc();
      req = 8'h00;
      chk("single_valid", v_rr, 64'd1);
      chk("single_id", id_rr, 64'd2);
      chk("single_rd", rd_rr, 64'd5);
      chk("single_data", d_rr, 64'hDEADBEEF);
      cyc();
      chk("single_idle", v_rr, 64'd0);
      chk("single_hold", d_rr, 64'hDEADBEEF);

      // round-robin from rr_ptr=0 after reset
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      req = 8'b0100_1010;
      #1;
      chk("rr_g1", g_rr, 64'h02);
      cyc();
      chk("rr_id1", id_rr, 64'd1);
      req = 8'b0100_1000;
      #1;
      chk("rr_g3", g_rr, 64'h08);
      cyc();
      chk("rr_id3", id_rr, 64'd3);
      req = 8'b0100_0000;
      #1;
      chk("rr_g6", g_rr, 64'h40);
      cyc();
      chk("rr_id6", id_rr, 64'd6);
      chk("rr_stall", s_rr, 64'd2);
      req = 8'b1000_0001;
      #1;
      chk("wrap_g7", g_rr, 64'h80);
      cyc();
      chk("wrap_id7", id_rr, 64'd7);
      req = 8'b0000_0001;
      #1;
      chk("wrap_g0", g_rr, 64'h01);
      cyc();
      chk("wrap_id0", id_rr, 64'd0);
      req = 8'h00;

      // oldest-first
      set_fu(0, 5'd10, 32'h1000, 64'd20);
      set_fu(4, 5'd14, 32'h4000, 64'd7);
      set_fu(5, 5'd15, 32'h5000, 64'd7);
      req = 8'b0011_0001;
      #1;
      chk("of_g4", g_of, 64'h10);
      cyc();
      chk("of_id4", id_of, 64'd4);
      chk("of_ord4", o_of, 64'd7);
      req = 8'b0010_0001;
      #1;
      chk("of_g5", g_of, 64'h20);
      cyc();
      chk("of_ord5", o_of, 64'd7);
      chk("of_rd5", rd_of, 64'd15);
      req = 8'b0000_0001;
      #1;
      chk("of_g0", g_of, 64'h01);
      cyc();
      chk("of_ord0", o_of, 64'd20);
      chk("of_data0", d_of, 64'h1000);
      req = 8'h00;

      // flush
      req = 8'b0000_0100;
      #1;
      chk("fl_g2", g_rr, 64'h04);
      cyc();
      flush = 1'b1;
      req = 8'b0000_1001;
      #1;
      chk("fl_nogrant", {48'd0, g_rr, g_of}, 64'd0);
      chk("fl_valid_t1", v_rr, 64'd1);
      chk("fl_id_t1", id_rr, 64'd2);
      cyc();
      flush = 1'b0;
      chk("fl_valid_t2", v_rr, 64'd0);
      chk("fl_stall", s_rr, 64'd5);
      #1;
      chk("fl_rrptr3", g_rr, 64'h08);
      cyc();
      chk("fl_id3", id_rr, 64'd3);
      chk("fl_stall2", s_rr, 64'd6);
      req = 8'h00;
      cyc();

      // saturation of the 4-bit counter (starts at 6)
      req = 8'b0000_0011;
      for (int i = 0; i < 8; i++) cyc();
      chk("sat_14", s_sat, 64'd14);
      cyc();
      chk("sat_15", s_sat, 64'd15);
      for (int i = 0; i < 11; i++) cyc();
      chk("sat_hold", s_sat, 64'd15);
      chk("sat_wide", s_rr, 64'd26);
      req = 8'h00;
      cyc();

      // reset mid-operation
      req = 8'b0000_0100;
      cyc();
      chk("mid_valid_pre", v_rr, 64'd1);
      rst = 1'b1;
      req = 8'b0110_0000;
      #1;
      chk("mid_grant_rst", g_rr, 64'd0);
      cyc();
      chk("mid_valid", v_rr, 64'd0);
      chk("mid_stall", s_rr, 64'd0);
      rst = 1'b0;
      req = 8'b1000_0010;
      #1;
      chk("mid_scan0", g_rr, 64'h02);
      cyc();
      req = 8'h00;
      chk("mid_id", id_rr, 64'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
